// File: rtl/shift_sequencer.sv
// Command sequencer for a universal shift register: parallel load, or a multi-cycle shift/rotate by a count.
// A load or shift spends one register edge per step, then pulses done. cmd_ready is high only in IDLE.
module shift_sequencer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [1:0]       cmd_fill,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [WIDTH-1:0] q_in,
  output logic [1:0]       usr_sel,
  output logic             usr_sr,
  output logic             usr_sl,
  output logic [WIDTH-1:0] usr_din,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  localparam logic [1:0] OP_SHR  = 2'b01;
  localparam logic [1:0] OP_SHL  = 2'b10;
  localparam logic [1:0] OP_LOAD = 2'b11;

  state_t           state, state_nxt;
  logic [1:0]       op_q;
  logic [1:0]       fill_q;
  logic [CNT_W-1:0] remaining;
  logic [WIDTH-1:0] din_q;
  logic             accept;

  assign accept  = cmd_valid & cmd_ready;
  assign usr_din = din_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      op_q      <= 2'b00;
      fill_q    <= 2'b00;
      remaining <= '0;
      din_q     <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_q      <= cmd_op;
        fill_q    <= cmd_fill;
        remaining <= cmd_count;
        din_q     <= cmd_data;
      end else if (state == SHIFT) begin
        remaining <= remaining - 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    usr_sel   = 2'b00;
    usr_sr    = 1'b0;
    usr_sl    = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) begin
          if (cmd_op == OP_LOAD)
            state_nxt = LOAD;
          else if ((cmd_op == OP_SHR || cmd_op == OP_SHL) && cmd_count != '0)
            state_nxt = SHIFT;
          else
            state_nxt = DONE;
        end
      end
      LOAD: begin
        usr_sel   = OP_LOAD;
        state_nxt = DONE;
      end
      SHIFT: begin
        usr_sel = op_q;
        // Rotate and arithmetic fill bits come from the register's live contents.
        if (op_q == OP_SHR) begin
          case (fill_q)
            2'b00:   usr_sr = 1'b0;
            2'b01:   usr_sr = 1'b1;
            2'b10:   usr_sr = q_in[0];
            default: usr_sr = q_in[WIDTH-1];
          endcase
        end else begin
          case (fill_q)
            2'b00:   usr_sl = 1'b0;
            2'b01:   usr_sl = 1'b1;
            2'b10:   usr_sl = q_in[WIDTH-1];
            default: usr_sl = 1'b0;
          endcase
        end
        if (remaining == CNT_W'(1))
          state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: a 4-bit register model driven by usr_* and a done-triggered scoreboard.
module tb_shift_sequencer;

  localparam int W = 4;
  localparam int C = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [1:0]   cmd_op = 2'b00;
  logic [1:0]   cmd_fill = 2'b00;
  logic [C-1:0] cmd_count = '0;
  logic [W-1:0] cmd_data = '0;
  logic [W-1:0] q = '0;
  logic [1:0]   usr_sel;
  logic         usr_sr, usr_sl;
  logic [W-1:0] usr_din;
  logic         busy, done;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int done_cyc = -10;

  typedef struct {
    string        name;
    logic [W-1:0] q;
    int           busy_cyc;
    int           shr_cyc;
    int           shl_cyc;
    int           ld_cyc;
  } exp_t;
  exp_t sb[$];

  shift_sequencer #(.WIDTH(W), .CNT_W(C)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_fill(cmd_fill), .cmd_count(cmd_count), .cmd_data(cmd_data),
    .q_in(q), .usr_sel(usr_sel), .usr_sr(usr_sr), .usr_sl(usr_sl), .usr_din(usr_din),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Universal shift register controlled by the DUT; it deliberately ignores rst.
  always @(posedge clk) begin
    case (usr_sel)
      2'b01:   q <= {usr_sr, q[W-1:1]};
      2'b10:   q <= {q[W-2:0], usr_sl};
      2'b11:   q <= usr_din;
      default: q <= q;
    endcase
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: counts per-command activity and checks it against the scoreboard on each done pulse.
  initial begin
    int busy_n, shr_n, shl_n, ld_n;
    exp_t e;
    busy_n = 0; shr_n = 0; shl_n = 0; ld_n = 0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (rst) begin
        busy_n = 0; shr_n = 0; shl_n = 0; ld_n = 0;
      end else begin
        if (busy) begin
          busy_n++;
          chk("ready_low_while_busy", {31'd0, cmd_ready}, 32'd0);
        end
        if (usr_sel == 2'b01) shr_n++;
        if (usr_sel == 2'b10) shl_n++;
        if (usr_sel == 2'b11) ld_n++;
        if (done) begin
          done_cyc = cyc;
          tests++;
          if (sb.size() == 0) begin
            fails++;
            $display("FAIL unexpected_done: got done=1 expected no pending command (t=%0t)", $time);
          end else begin
            e = sb.pop_front();
            chk({e.name, "_q"},     {28'd0, q}, {28'd0, e.q});
            chk({e.name, "_busy"},  busy_n, e.busy_cyc);
            chk({e.name, "_shr"},   shr_n,  e.shr_cyc);
            chk({e.name, "_shl"},   shl_n,  e.shl_cyc);
            chk({e.name, "_load"},  ld_n,   e.ld_cyc);
          end
          busy_n = 0; shr_n = 0; shl_n = 0; ld_n = 0;
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge with cmd_valid still high.
  task automatic send(input string nm, input logic [1:0] op, input logic [1:0] fill,
                      input int cnt, input logic [W-1:0] data, input logic [W-1:0] exp_q,
                      input int exp_busy, input int exp_shr, input int exp_shl, input int exp_ld,
                      input bit push, input bit b2b);
    bit acc = 0;
    exp_t e;
    cmd_op = op; cmd_fill = fill; cmd_count = C'(cnt); cmd_data = data; cmd_valid = 1'b1;
    for (int i = 0; i < 200 && !acc; i++) begin
      if (cmd_ready) begin
        acc = 1;
        if (b2b) chk({nm, "_accept_after_done"}, cyc, done_cyc + 1);
        if (push) begin
          e.name = nm; e.q = exp_q; e.busy_cyc = exp_busy;
          e.shr_cyc = exp_shr; e.shl_cyc = exp_shl; e.ld_cyc = exp_ld;
          sb.push_back(e);
        end
      end
      @(negedge clk);
    end
    if (!acc) begin
      tests++; fails++;
      $display("FAIL %s_accept_timeout: got no acceptance expected acceptance within 200 cycles", nm);
    end
  endtask

  task automatic wait_idle(input string nm);
    cmd_valid = 1'b0;
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      tests++; fails++;
      $display("FAIL %s_done_timeout: got %0d pending expected 0", nm, sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_busy",  {31'd0, busy}, 32'd0);
    chk("rst_done",  {31'd0, done}, 32'd0);
    chk("rst_sel",   {30'd0, usr_sel}, 32'd0);
    chk("rst_serial", {30'd0, usr_sr, usr_sl}, 32'd0);
    chk("rst_din",   {28'd0, usr_din}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    //   name        op     fill   cnt data     exp_q    busy shr shl ld push b2b
    send("load1",    2'b11, 2'b00, 0, 4'b1011, 4'b1011, 2, 0, 0, 1, 1, 0); wait_idle("load1");
    send("shr_zero", 2'b01, 2'b00, 1, 4'b0000, 4'b0101, 2, 1, 0, 0, 1, 0); wait_idle("shr_zero");
    send("load2",    2'b11, 2'b00, 0, 4'b1011, 4'b1011, 2, 0, 0, 1, 1, 0); wait_idle("load2");
    send("shl_rot3", 2'b10, 2'b10, 3, 4'b0000, 4'b1101, 4, 0, 3, 0, 1, 0); wait_idle("shl_rot3");
    send("load3",    2'b11, 2'b00, 0, 4'b1011, 4'b1011, 2, 0, 0, 1, 1, 0); wait_idle("load3");
    send("shr_ari2", 2'b01, 2'b11, 2, 4'b0000, 4'b1110, 3, 2, 0, 0, 1, 0); wait_idle("shr_ari2");
    send("shr_one7", 2'b01, 2'b01, 7, 4'b0000, 4'b1111, 8, 7, 0, 0, 1, 0); wait_idle("shr_one7");
    send("nop",      2'b00, 2'b00, 5, 4'b0101, 4'b1111, 1, 0, 0, 0, 1, 0); wait_idle("nop");
    send("shr_cnt0", 2'b01, 2'b01, 0, 4'b0000, 4'b1111, 1, 0, 0, 0, 1, 0); wait_idle("shr_cnt0");

    send("b2b_shl2", 2'b10, 2'b00, 2, 4'b0000, 4'b1100, 3, 0, 2, 0, 1, 0);
    send("b2b_load", 2'b11, 2'b00, 0, 4'b0110, 4'b0110, 2, 0, 0, 1, 1, 1); wait_idle("b2b");

    send("shl_ari1", 2'b10, 2'b11, 1, 4'b0000, 4'b1100, 2, 0, 1, 0, 1, 0); wait_idle("shl_ari1");
    send("load4",    2'b11, 2'b00, 0, 4'b1001, 4'b1001, 2, 0, 0, 1, 1, 0); wait_idle("load4");
    send("shr_rot5", 2'b01, 2'b10, 5, 4'b0000, 4'b1100, 6, 5, 0, 0, 1, 0); wait_idle("shr_rot5");
    send("shl_one2", 2'b10, 2'b01, 2, 4'b0000, 4'b0011, 3, 0, 2, 0, 1, 0); wait_idle("shl_one2");

    // Reset in the second cycle of a 4-step left shift: one shift has landed.
    send("load5",    2'b11, 2'b00, 0, 4'b1011, 4'b1011, 2, 0, 0, 1, 1, 0); wait_idle("load5");
    send("shl_abrt", 2'b10, 2'b00, 4, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0);
    cmd_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_sel",   {30'd0, usr_sel}, 32'd0);
    chk("midrst_busy",  {31'd0, busy}, 32'd0);
    chk("midrst_done",  {31'd0, done}, 32'd0);
    chk("midrst_ready", {31'd0, cmd_ready}, 32'd1);
    repeat (2) @(negedge clk);
    chk("midrst_q_hold", {28'd0, q}, {28'd0, 4'b0110});
    rst = 1'b0;
    @(negedge clk);
    send("post_rst", 2'b01, 2'b01, 1, 4'b0000, 4'b1011, 2, 1, 0, 0, 1, 0); wait_idle("post_rst");

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
Command-driven controller that sequences a WIDTH-bit universal shift register: parallel loads and multi-cycle shifts or rotates by a programmable count.
Accepts one command at a time over a valid/ready handshake and drives the register's select, serial-in and parallel-data inputs.
Reads the register's output back to generate rotate and arithmetic fill bits, then signals completion with a one-cycle done pulse.
Sits between a CPU/bus-side command source and the shift register datapath.

Parameters:
WIDTH, 4, width of the controlled shift register and of cmd_data / usr_din / q_in
CNT_W, 4, width of cmd_count; counts 0..2^CNT_W-1 are legal

Ports:
clk  in  1  clock; all state changes on posedge
rst  in  1  reset, asynchronous, active-high
cmd_valid  in  1  command present
cmd_ready  out  1  controller can accept a command (high only in IDLE)
cmd_op  in  2  00 NOP, 01 shift right, 10 shift left, 11 parallel load
cmd_fill  in  2  00 zero fill, 01 ones fill, 10 rotate, 11 arithmetic
cmd_count  in  CNT_W  number of single-bit shift steps (ignored for LOAD/NOP)
cmd_data  in  WIDTH  load value (used for LOAD only)
q_in  in  WIDTH  current contents of the controlled register
usr_sel  out  2  register select: 00 hold, 01 shift right (serial bit enters MSB), 10 shift left (serial bit enters LSB), 11 parallel load
usr_sr  out  1  serial bit entering the MSB on a right shift
usr_sl  out  1  serial bit entering the LSB on a left shift
usr_din  out  WIDTH  parallel load data
busy  out  1  command in progress (state != IDLE)
done  out  1  one-cycle pulse on command completion

Behaviour:
- Reset (async, any time, including mid-command): state=IDLE. Outputs: cmd_ready=1, busy=0, done=0, usr_sel=00, usr_sr=0, usr_sl=0. Internal regs (usr_din, op, fill, remaining) are cleared to 0. The pending command is discarded and the register keeps its current contents.
- States: IDLE, LOAD, SHIFT, DONE.
- IDLE: cmd_ready=1, usr_sel=00. Acceptance is cmd_valid & cmd_ready at a posedge. At acceptance, op, fill, data and count are latched. Next state:
  - LOAD if op=11.
  - SHIFT if op is 01 or 10 and count≠0.
  - DONE if op=00, or if op is 01/10 with count=0.
- LOAD: usr_sel=11, usr_din=latched data, for exactly one cycle. Next state is DONE.
- SHIFT: usr_sel=01 or 10 per the latched op. remaining is decremented each cycle. When remaining==1, the next state is DONE. Exactly count register edges are spent shifting.
- DONE: usr_sel=00, done=1 for exactly one cycle. Next state is IDLE.
- Latency for a shift command accepted at edge E0:
  - shifts occur at edges E1..En;
  - done is high in the cycle after En;
  - cmd_ready is high again after edge En+1.
- LOAD latency: load at E1, done in the cycle after E1. NOP / zero count: done in the cycle after E0, with no register activity.
- Serial bits are combinational from state, fill and q_in. They are driven only in SHIFT and are 0 otherwise.
  - Right shift: zero→0; ones→1; rotate→q_in[0]; arithmetic→q_in[WIDTH-1].
  - Left shift: zero→0; ones→1; rotate→q_in[WIDTH-1]; arithmetic→0.
- Counts greater than WIDTH are legal. Rotates wrap modulo WIDTH. Fills saturate (all bits become the fill value).
- cmd_ready=0 while busy. A command held valid during busy is accepted only in the next IDLE cycle. No command is dropped or duplicated.
- cmd_* inputs are don't-care except at the acceptance edge.

Test Plan:
- WIDTH=4, bench models the register per the usr_sel contract. Sequence: LOAD 4'b1011, then SHR fill=zero count=1. Required: q=0101 after the shift; done pulses once per command; exactly one usr_sel=01 cycle.
- LOAD 1011, then SHL fill=rotate count=3 → q=1101. Required: usr_sel=10 for exactly 3 consecutive cycles, done the following cycle.
- LOAD 1011, then SHR fill=arith count=2 → q=1110. Separately, SHR fill=ones count=7 → q=1111.
- NOP, and SHR with count=0. Required: done in the cycle after acceptance; usr_sel stays 00; q unchanged.
- Hold cmd_valid high with back-to-back commands (SHL count=2, then LOAD 0110). Required: the second command is accepted only in the IDLE cycle after the first command's done; final q=0110; cmd_ready=0 throughout busy.
- Assert rst during the 2nd cycle of an SHL count=4. Required: immediate usr_sel=00, busy=0, no done pulse, and q holds the value reached after 1 shift. A new command is accepted normally after reset release.
